// File: rtl/jk_ubus_pkg.sv
// Shared UBUS slave types: burst size encoding, responder FSM states, latched transfer context.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package jk_ubus_pkg;

  typedef enum logic [1:0] {
    SZ_1 = 2'b00,
    SZ_2 = 2'b01,
    SZ_4 = 2'b10,
    SZ_8 = 2'b11
  } ubus_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR
  } ubus_slv_state_e;

  typedef struct packed {
    logic       is_write;
    logic [2:0] last_beat;
  } ubus_xfer_t;

  function automatic logic [3:0] size_to_beats(input ubus_size_e sz);
    logic [3:0] beats;
    case (sz)
      SZ_1:    beats = 4'd1;
      SZ_2:    beats = 4'd2;
      SZ_4:    beats = 4'd4;
      SZ_8:    beats = 4'd8;
      default: beats = 4'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/jk_ubus_slave_mem.sv
// Backing store for the slave window: one synchronous write port, one asynchronous read port.
// Latency: read is combinational, write lands on the clock edge.
// Backpressure: none; contents are deliberately not reset.
module jk_ubus_slave_mem #(
  parameter int DATA_W = 8,
  parameter int WORDS  = 256,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jk_ubus_mem_slave.sv
// UBUS slave responder: one decoded address window backed by RAM, 1/2/4/8-beat bursts, error on miss/RO write.
// Latency: beat k completes WAIT_CYCLES + k*(WAIT_CYCLES+1) + 1 cycles after the address-phase cycle.
// Backpressure: each beat is stalled WAIT_CYCLES cycles via wait_state; new requests are taken only in IDLE.
module jk_ubus_mem_slave
  import jk_ubus_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                MEM_BYTES   = 256,
  parameter int                WAIT_CYCLES = 0,
  parameter int                RO          = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              read,
  input  logic              write,
  input  logic              bip,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              wait_state,
  output logic              error,
  output logic              busy,
  output logic              proto_err
);

  localparam int BPB     = DATA_W / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int OFF_W   = $clog2(MEM_BYTES);
  localparam int WORDS   = MEM_BYTES / BPB;
  localparam int IDX_W   = OFF_W - LOG_BPB;

  localparam logic [ADDR_W:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI    = WIN_LO + (ADDR_W+1)'(MEM_BYTES - 1);
  localparam bit              HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]      WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  ubus_slv_state_e   state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [2:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  ubus_xfer_t        xfer_q, xfer_d;

  logic [3:0]        req_beats;
  logic [ADDR_W:0]   req_last;
  logic              req_hit;
  logic              last_beat;
  logic              bip_bad;
  logic              proto_set;
  logic              mem_we;
  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  // Decode in ADDR_W+1 bits so a burst running off the top of the address space shows up as a miss.
  always_comb begin
    req_beats = size_to_beats(ubus_size_e'(size));
    req_last  = {1'b0, addr} + ((ADDR_W+1)'(req_beats) << LOG_BPB) - (ADDR_W+1)'(1);
    req_hit   = ({1'b0, addr} >= WIN_LO) && !req_last[ADDR_W] && (req_last <= WIN_HI);
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    xfer_d    = xfer_q;
    proto_set = 1'b0;
    mem_we    = 1'b0;
    last_beat = (beat_q == xfer_q.last_beat);
    bip_bad   = (bip == last_beat);

    case (state_q)
      ST_IDLE: begin
        if (read && write) begin
          proto_set = 1'b1;
        end else if (read || write) begin
          addr_d           = addr;
          beat_d           = '0;
          xfer_d.is_write  = write;
          xfer_d.last_beat = 3'(req_beats - 4'd1);
          if (!req_hit || (RO != 0 && write)) begin
            state_d = ST_ERR;
          end else if (HAS_WAIT) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_DATA: begin
        mem_we    = xfer_q.is_write;
        proto_set = bip_bad;
        addr_d    = addr_q + ADDR_W'(BPB);
        if (last_beat) begin
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_ERR: begin
        // bip is only checked here; the beat counter alone decides when the error phase ends.
        proto_set = bip_bad;
        if (last_beat) begin
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      xfer_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      xfer_q    <= xfer_d;
      proto_err <= proto_err | proto_set;
    end
  end

  assign offset  = OFF_W'(addr_q) - OFF_W'(BASE_ADDR);
  assign mem_idx = offset[OFF_W-1:LOG_BPB];

  jk_ubus_slave_mem #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_idx),
    .wdata (data_in),
    .raddr (mem_idx),
    .rdata (mem_rdata)
  );

  // All responses decode straight from the state register, so an async reset clears them at once.
  assign busy       = (state_q != ST_IDLE);
  assign wait_state = (state_q == ST_WAIT);
  assign error      = (state_q == ST_ERR);
  assign data_oe    = (state_q == ST_DATA) && !xfer_q.is_write;
  assign data_out   = data_oe ? mem_rdata : '0;

endmodule
